// File: rtl/conv_rd_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : conv_rd_bus_arbiter
//  Purpose  : Round-robin arbiter that shares one AXI-style read bus between
//             NREQ read clients (conv fetch, weight, bias/param, spare).
//             It allows one outstanding burst at a time, tags each burst with
//             ID_BASE+client, routes R beats only to the owner, and has a
//             watchdog that frees the bus when a burst stalls.
//  Ports    : clk/rst           - clock, asynchronous active-high reset
//             req_ar*           - per-client read-address request channel
//             req_r*            - per-client read-data return (data broadcast)
//             ar*/r*            - shared bus AR and R channels
//             busy, grant_idx   - arbiter status
//             timeout_err       - sticky watchdog abort flag
//             rid_err           - 1-cycle pulse on stray or mis-sized beat
//  Revision : 1.0 - initial release
// ============================================================================
module conv_rd_bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 28,
    parameter int DW      = 32,
    parameter int ID_BASE = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_arvalid,
    input  logic [NREQ*AW-1:0]  req_araddr,
    input  logic [NREQ*4-1:0]   req_arlen,
    input  logic [NREQ-1:0]     req_aruser_ap,
    output logic [NREQ-1:0]     req_arready,
    output logic [NREQ-1:0]     req_rvalid,
    output logic                req_rlast,
    output logic [DW-1:0]       req_rdata,
    output logic                arvalid,
    input  logic                arready,
    output logic [AW-1:0]       araddr,
    output logic [3:0]          arlen,
    output logic [3:0]          aruser_id,
    output logic                aruser_ap,
    input  logic                rvalid,
    input  logic                rlast,
    input  logic [3:0]          rid,
    input  logic [DW-1:0]       rdata,
    output logic                busy,
    output logic [2:0]          grant_idx,
    output logic                timeout_err,
    output logic                rid_err
);

    localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          state;
    logic [GW-1:0]   rr_ptr;
    logic [3:0]      beat_cnt;
    logic [WDW-1:0]  wdog;

    logic [GW-1:0]   gsel;
    logic [NREQ-1:0] gnt_oh;
    logic [3:0]      gnt_id;
    logic [GW-1:0]   nxt_ptr;
    logic [GW-1:0]   pick;
    logic            in_addr;
    logic            beat_ok;
    logic            len_err;
    logic            stray;

    assign gsel    = grant_idx[GW-1:0];
    assign gnt_oh  = NREQ'(1) << gsel;
    assign gnt_id  = 4'(ID_BASE) + 4'(gsel);
    assign nxt_ptr = (gsel == GW'(NREQ - 1)) ? '0 : gsel + GW'(1);
    assign in_addr = (state == ST_ADDR);
    assign busy    = (state != ST_IDLE);

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        int  idx;
        logic found;
        pick  = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && req_arvalid[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    // AR channel is a straight mux of the granted client while in ADDR and
    // held at zero otherwise.
    always_comb begin
        arvalid     = 1'b0;
        araddr      = '0;
        arlen       = '0;
        aruser_id   = '0;
        aruser_ap   = 1'b0;
        req_arready = '0;
        if (in_addr) begin
            arvalid     = req_arvalid[gsel];
            araddr      = req_araddr[gsel*AW +: AW];
            arlen       = req_arlen[gsel*4 +: 4];
            aruser_id   = gnt_id;
            aruser_ap   = req_aruser_ap[gsel];
            req_arready = arready ? gnt_oh : '0;
        end
    end

    // A beat belongs to the current burst only in DATA with the owner's ID;
    // anything else on the R channel is stray and is dropped.
    assign beat_ok = (state == ST_DATA) && rvalid && (rid == gnt_id);
    assign len_err = beat_ok && (rlast ? (beat_cnt != 4'd0) : (beat_cnt == 4'd0));
    assign stray   = rvalid && !beat_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            grant_idx   <= '0;
            beat_cnt    <= '0;
            wdog        <= '0;
            req_rvalid  <= '0;
            req_rlast   <= 1'b0;
            req_rdata   <= '0;
            timeout_err <= 1'b0;
            rid_err     <= 1'b0;
        end else begin
            req_rvalid <= '0;
            req_rlast  <= 1'b0;
            rid_err    <= stray | len_err;
            case (state)
                ST_IDLE: begin
                    if (|req_arvalid) begin
                        grant_idx <= 3'(pick);
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (arvalid && arready) begin
                        beat_cnt <= arlen;
                        wdog     <= '0;
                        state    <= ST_DATA;
                    end else if (!req_arvalid[gsel]) begin
                        // Client withdrew; it keeps its turn.
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (beat_ok) begin
                        req_rvalid <= gnt_oh;
                        req_rlast  <= rlast;
                        req_rdata  <= rdata;
                        wdog       <= '0;
                        if (beat_cnt != 4'd0) begin
                            beat_cnt <= beat_cnt - 4'd1;
                        end
                        // rlast always ends the burst, even if mis-sized.
                        if (rlast) begin
                            state  <= ST_IDLE;
                            rr_ptr <= nxt_ptr;
                        end
                    end else if (wdog == WDW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                        rr_ptr      <= nxt_ptr;
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_rd_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_rd_bus_arbiter
//  Purpose  : Self-checking bench for conv_rd_bus_arbiter: a table of full
//             bursts with hand-computed grants, plus directed sequences for
//             AR back-pressure, stray beats, watchdog abort and mid-burst reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_rd_bus_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 28;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_arvalid;
    logic [NREQ*AW-1:0] req_araddr;
    logic [NREQ*4-1:0] req_arlen;
    logic [NREQ-1:0]   req_aruser_ap;
    logic [NREQ-1:0]   req_arready;
    logic [NREQ-1:0]   req_rvalid;
    logic              req_rlast;
    logic [DW-1:0]     req_rdata;
    logic              arvalid;
    logic              arready;
    logic [AW-1:0]     araddr;
    logic [3:0]        arlen;
    logic [3:0]        aruser_id;
    logic              aruser_ap;
    logic              rvalid;
    logic              rlast;
    logic [3:0]        rid;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [2:0]        grant_idx;
    logic              timeout_err;
    logic              rid_err;

    conv_rd_bus_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .ID_BASE(1), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr),
        .req_arlen(req_arlen), .req_aruser_ap(req_aruser_ap),
        .req_arready(req_arready), .req_rvalid(req_rvalid),
        .req_rlast(req_rlast), .req_rdata(req_rdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arlen(arlen), .aruser_id(aruser_id), .aruser_ap(aruser_ap),
        .rvalid(rvalid), .rlast(rlast), .rid(rid), .rdata(rdata),
        .busy(busy), .grant_idx(grant_idx),
        .timeout_err(timeout_err), .rid_err(rid_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  len;
        logic [27:0] base;
        int          g;
        logic [3:0]  id;
    } vec_t;

    vec_t tab[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Client i sees address base + i*0x1000, same length, ap = i[0].
    task automatic set_req(input logic [3:0] mask, input logic [3:0] len, input logic [27:0] base);
        req_arvalid = mask;
        for (int i = 0; i < NREQ; i++) begin
            req_araddr[i*AW +: AW] = base + 28'(i << 12);
            req_arlen[i*4 +: 4]    = len;
            req_aruser_ap[i]       = i[0];
        end
    endtask

    task automatic beat(input logic [3:0] id, input logic last, input logic [31:0] d);
        rvalid = 1'b1;
        rid    = id;
        rlast  = last;
        rdata  = d;
        step();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        rst = 1'b1;
        req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_aruser_ap = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rid = '0; rdata = '0;

        // Round-robin from reset, then mixed masks; grants worked by hand.
        tab[0] = '{4'b1111, 4'd0, 28'h0010000, 0, 4'd1};
        tab[1] = '{4'b1111, 4'd0, 28'h0020000, 1, 4'd2};
        tab[2] = '{4'b1111, 4'd0, 28'h0030000, 2, 4'd3};
        tab[3] = '{4'b1111, 4'd0, 28'h0040000, 3, 4'd4};
        tab[4] = '{4'b1111, 4'd0, 28'h0050000, 0, 4'd1};
        tab[5] = '{4'b0001, 4'd3, 28'h0000100, 0, 4'd1};
        tab[6] = '{4'b1010, 4'd1, 28'h0060000, 1, 4'd2};
        tab[7] = '{4'b1010, 4'd1, 28'h0070000, 3, 4'd4};
        tab[8] = '{4'b0100, 4'd2, 28'h0080000, 2, 4'd3};
        tab[9] = '{4'b1001, 4'd0, 28'h0090000, 3, 4'd4};

        step(); step();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_rid_err", rid_err, 0);
        chk("rst_rvalid", req_rvalid, 0);
        chk("rst_rdata", req_rdata, 0);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            set_req(tab[v].mask, tab[v].len, tab[v].base);
            step();
            chk("t_arvalid", arvalid, 1);
            chk("t_grant", grant_idx, 64'(tab[v].g));
            chk("t_id", aruser_id, tab[v].id);
            chk("t_araddr", araddr, tab[v].base + 28'(tab[v].g << 12));
            chk("t_arlen", arlen, tab[v].len);
            chk("t_ap", aruser_ap, 64'(tab[v].g & 1));
            chk("t_arready_lo", req_arready, 0);
            arready = 1'b1;
            #1;
            chk("t_arready_hi", req_arready, 64'(1 << tab[v].g));
            step();
            arready = 1'b0;
            #1;
            chk("t_data_arvalid", arvalid, 0);
            chk("t_data_araddr", araddr, 0);
            chk("t_data_busy", busy, 1);
            for (int b = 0; b <= int'(tab[v].len); b++) begin
                d = 32'hA000_0000 | 32'(v << 8) | 32'(b);
                beat(tab[v].id, b == int'(tab[v].len), d);
                chk("t_rvalid", req_rvalid, 64'(1 << tab[v].g));
                chk("t_rdata", req_rdata, d);
                chk("t_rlast", req_rlast, 64'(b == int'(tab[v].len)));
                chk("t_rid_err", rid_err, 0);
            end
            chk("t_idle", busy, 0);
        end
        set_req(4'b0000, 4'd0, 28'h0);

        // AR back-pressure on client 2, then a stray beat mid-burst.
        set_req(4'b0100, 4'd1, 28'h0200000);
        step();
        chk("bp_grant", grant_idx, 2);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_arvalid", arvalid, 1);
            chk("bp_araddr", araddr, 28'h0202000);
            chk("bp_arready", req_arready, 0);
        end
        arready = 1'b1;
        #1;
        chk("bp_arready_pulse", req_arready, 4'b0100);
        step();
        arready = 1'b0;
        #1;
        chk("bp_arready_after", req_arready, 0);
        beat(4'd3, 1'b0, 32'h1111_0000);
        chk("st_b0_rvalid", req_rvalid, 4'b0100);
        chk("st_b0_err", rid_err, 0);
        beat(4'd1, 1'b0, 32'hDEAD_BEEF);
        chk("st_stray_rvalid", req_rvalid, 0);
        chk("st_stray_err", rid_err, 1);
        beat(4'd3, 1'b1, 32'h1111_0001);
        chk("st_b1_rvalid", req_rvalid, 4'b0100);
        chk("st_b1_rlast", req_rlast, 1);
        chk("st_b1_rdata", req_rdata, 32'h1111_0001);
        chk("st_b1_err", rid_err, 0);
        set_req(4'b0000, 4'd0, 28'h0);
        beat(4'd1, 1'b0, 32'h0);
        chk("idle_stray_err", rid_err, 1);
        chk("idle_stray_rvalid", req_rvalid, 0);
        step();
        chk("idle_err_clear", rid_err, 0);

        // Watchdog: rr_ptr=3, so client 0 wins; no data ever returns.
        set_req(4'b0011, 4'd0, 28'h0300000);
        step();
        chk("wd_grant", grant_idx, 0);
        arready = 1'b1;
        step();
        arready = 1'b0;
        for (int k = 0; k < 15; k++) step();
        chk("wd_not_yet", timeout_err, 0);
        chk("wd_busy", busy, 1);
        step();
        chk("wd_timeout", timeout_err, 1);
        chk("wd_idle", busy, 0);
        chk("wd_no_rlast", req_rlast, 0);
        step();
        chk("wd_next_grant", grant_idx, 1);
        chk("wd_next_id", aruser_id, 2);
        set_req(4'b0000, 4'd0, 28'h0);
        step();
        chk("wd_withdraw_idle", busy, 0);
        chk("wd_sticky", timeout_err, 1);

        // Reset after 2 of 4 beats of client 2's burst.
        set_req(4'b0100, 4'd3, 28'h0400000);
        step();
        chk("rs_grant", grant_idx, 2);
        arready = 1'b1;
        step();
        arready = 1'b0;
        beat(4'd3, 1'b0, 32'h2222_0000);
        beat(4'd3, 1'b0, 32'h2222_0001);
        chk("rs_pre_rdata", req_rdata, 32'h2222_0001);
        set_req(4'b0000, 4'd0, 28'h0);
        rst = 1'b1;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_rvalid", req_rvalid, 0);
        chk("rs_rdata", req_rdata, 0);
        chk("rs_timeout", timeout_err, 0);
        chk("rs_grant0", grant_idx, 0);
        step();
        rst = 1'b0;
        beat(4'd3, 1'b0, 32'h2222_0002);
        chk("rs_late_err", rid_err, 1);
        chk("rs_late_rvalid", req_rvalid, 0);
        beat(4'd3, 1'b1, 32'h2222_0003);
        chk("rs_late2_err", rid_err, 1);
        chk("rs_late2_rvalid", req_rvalid, 0);
        set_req(4'b1111, 4'd0, 28'h0500000);
        step();
        chk("rs_new_grant", grant_idx, 0);
        chk("rs_new_id", aruser_id, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_rd_bus_arbiter.md
Name: conv_rd_bus_arbiter

Overview:
- Shares the single accelerator read bus between up to NREQ read clients: conv input fetch, weight loader, bias/param loader and a spare.
- Clients present AXI-style read-address requests. The arbiter grants one client at a time in round-robin order and drives the bus AR channel from that client.
- It tags each burst with a per-client bus ID and routes returning R beats only to the owner.
- One burst is outstanding at a time. A watchdog releases the bus if a burst stalls.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 28, address width
DW, 32, read data width
ID_BASE, 1, bus ID for requester 0; requester i uses ID_BASE+i (must fit 4 bits)
TIMEOUT, 1024, idle cycles allowed in DATA before watchdog abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_arvalid  in  NREQ  per-client request valid
req_araddr  in  NREQ*AW  per-client address, client i at [i*AW +: AW]
req_arlen  in  NREQ*4  per-client burst length minus 1
req_aruser_ap  in  NREQ  per-client user attribute
req_arready  out  NREQ  per-client address accepted
req_rvalid  out  NREQ  per-client read beat valid
req_rlast  out  1  last beat; qualify with req_rvalid
req_rdata  out  DW  read data, broadcast to all clients
arvalid  out  1  bus address valid
arready  in  1  bus address ready
araddr  out  AW  bus address
arlen  out  4  bus burst length minus 1
aruser_id  out  4  bus ID = ID_BASE+grant
aruser_ap  out  1  bus user attribute
rvalid  in  1  bus beat valid
rlast  in  1  bus last beat
rid  in  4  bus beat ID
rdata  in  DW  bus beat data
busy  out  1  state != IDLE
grant_idx  out  3  current or last granted client
timeout_err  out  1  sticky; set on watchdog abort
rid_err  out  1  one-cycle pulse on stray/mismatched beat

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0, grant_idx=0.
  - All outputs 0: arvalid, araddr, arlen, aruser_id, aruser_ap, req_arready, req_rvalid, req_rlast, busy, timeout_err, rid_err.
  - req_rdata reset to 0.
  - Reset mid-burst aborts the burst silently; later beats are treated as stray.
- FSM is IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - If any req_arvalid is set, select the first set bit searching circularly from rr_ptr.
  - Register it into grant_idx and go to ADDR. Bus arvalid rises the cycle after the request is seen (1-cycle arbitration latency).
- ADDR:
  - Bus AR outputs combinationally mux client grant_idx: arvalid=req_arvalid[g], araddr, arlen, aruser_ap; aruser_id=ID_BASE+g.
  - req_arready[g]=arready. All other req_arready are 0.
  - On arvalid&&arready: load beat_cnt=arlen (captured), clear wdog, go to DATA.
  - If req_arvalid[g] drops without a handshake: return to IDLE, rr_ptr unchanged.
- DATA:
  - arvalid=0, and every other AR output is 0.
  - A beat with rvalid && rid==ID_BASE+g sets req_rvalid[g]=1, req_rlast=rlast, req_rdata=rdata (registered, 1-cycle latency) and clears wdog. beat_cnt decrements per beat without underflow.
  - On rlast: go to IDLE and set rr_ptr=(g+1) mod NREQ. A client granted back-to-back therefore gets the next grant no earlier than 2 cycles after its rlast.
  - If rlast arrives with beat_cnt!=0, or beat_cnt==0 without rlast (beat beyond length): pulse rid_err. Still honour rlast as end of burst.
  - While DATA has no accepted beat, wdog increments. When wdog==TIMEOUT-1: set timeout_err, go to IDLE, rr_ptr=(g+1) mod NREQ, no req_rlast issued.
- Stray beats: rvalid with rid not equal to the granted ID (any state), or rvalid in IDLE/ADDR. Pulse rid_err the next cycle, drop the data, no req_rvalid.
- req_rvalid is one-hot or zero at all times. Outputs go only to the granted client.
- timeout_err clears only on rst.
- Requests from non-granted clients wait with req_arready=0. The arbiter imposes no starvation beyond NREQ-1 bursts.

Test Plan:
- Single client: req_arvalid[0]=1, addr 0x0000100, arlen=3, arready=1. Required: arvalid at +1 with aruser_id=1; 4 beats rid=1 appear on req_rvalid[0] 1 cycle later; req_rlast on the 4th; busy falls; rr_ptr=1.
- All 4 clients request continuously, arlen=0. Required: grant order 0,1,2,3,0. Each aruser_id equals 1..4 in turn. No client gets two consecutive grants.
- arready held low 5 cycles in ADDR. Required: arvalid stays 1, araddr stable, req_arready[g]=0 until arready rises; then exactly one req_arready pulse.
- During client 2's burst (ID 3), inject a beat with rid=1. Required: rid_err pulses, no req_rvalid, client 2's beats unaffected. Also send rvalid in IDLE and check rid_err pulses.
- TIMEOUT=16; grant, handshake, then never return data. Required: 16 cycles later timeout_err=1 (sticky), state IDLE, next client granted. timeout_err stays 1 until rst.
- Assert rst for 1 cycle mid-DATA after 2 of 4 beats. Required: all outputs 0 immediately; remaining beats raise rid_err only; a new request afterwards is granted to client 0.
